// File: rtl/msrv32_pkg.sv
// Shared constants and types for the msrv32 instruction-fetch slice.
// Includes the fetch-queue entry layout and the instruction field positions.
package msrv32_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned QUEUE_DEPTH_DEF  = 32'd2;

  localparam int unsigned OPC_LSB = 32'd0;
  localparam int unsigned OPC_MSB = 32'd6;
  localparam int unsigned RD_LSB  = 32'd7;
  localparam int unsigned RD_MSB  = 32'd11;
  localparam int unsigned F3_LSB  = 32'd12;
  localparam int unsigned F3_MSB  = 32'd14;
  localparam int unsigned RS1_LSB = 32'd15;
  localparam int unsigned RS1_MSB = 32'd19;
  localparam int unsigned RS2_LSB = 32'd20;
  localparam int unsigned RS2_MSB = 32'd24;
  localparam int unsigned IMM_LSB = 32'd7;
  localparam int unsigned IMM_MSB = 32'd31;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
    logic        misalign;
  } fetch_entry_t;

  localparam fetch_entry_t EMPTY_ENTRY = '{pc: 32'h0000_0000, instr: NOP_INSTR,
                                           fault: 1'b0, misalign: 1'b0};

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/msrv32_fetch_queue.sv
// Two-entry FIFO of fetch entries; head is driven directly from storage registers.
// A push into a full queue is accepted only when a pop happens in the same cycle.
module msrv32_fetch_queue
  import msrv32_pkg::*;
#(
  parameter int unsigned DEPTH = QUEUE_DEPTH_DEF
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  fetch_entry_t entry0_r;
  fetch_entry_t entry1_r;
  logic         wr_ptr_r;
  logic         rd_ptr_r;
  logic [1:0]   count_r;
  logic         push_ok_s;
  logic         pop_ok_s;

  assign full  = (count_r == 2'(DEPTH));
  assign empty = (count_r == 2'd0);
  assign head  = rd_ptr_r ? entry1_r : entry0_r;

  // Qualify push/pop against occupancy.
  always_comb begin
    pop_ok_s  = pop & ~empty;
    push_ok_s = push & (~full | pop_ok_s);
  end

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      entry0_r <= EMPTY_ENTRY;
      entry1_r <= EMPTY_ENTRY;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else if (flush) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_ok_s) begin
        if (wr_ptr_r) begin
          entry1_r <= push_entry;
        end else begin
          entry0_r <= push_entry;
        end
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/msrv32_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word reads and buffers results.
// Handles redirects, bus errors and misaligned targets ahead of decode.
module msrv32_fetch_unit
  import msrv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned QUEUE_DEPTH = QUEUE_DEPTH_DEF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        redirect_in,
  input  logic [31:0] target_pc_in,
  output logic [31:0] i_addr_out,
  output logic        i_req_out,
  input  logic        i_ack_in,
  input  logic [31:0] i_rdata_in,
  input  logic        i_err_in,
  output logic        instr_valid_out,
  input  logic        instr_ready_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [24:0] imm_instr_out,
  output logic [6:0]  opcode_out,
  output logic [2:0]  funct3_out,
  output logic [4:0]  rd_addr_out,
  output logic [4:0]  rs1_addr_out,
  output logic [4:0]  rs2_addr_out,
  output logic        fetch_fault_out,
  output logic        fetch_misalign_out
);

  logic [31:0]  pc_r;
  logic         halt_r;
  logic         misalign_pend_r;
  logic         accept_s;
  logic         pop_s;
  logic         push_s;
  fetch_entry_t push_entry_s;
  logic         q_full_s;
  logic         q_empty_s;
  fetch_entry_t head_s;

  assign instr_valid_out = ~q_empty_s;
  assign pop_s           = instr_valid_out & instr_ready_in & ~redirect_in;
  assign i_req_out       = ~rst_in & ~redirect_in & ~halt_r & (~q_full_s | pop_s);
  assign accept_s        = i_req_out & i_ack_in;
  assign i_addr_out      = pc_r;

  // Select what enters the queue: a pending misalign marker or the acked bus word.
  always_comb begin
    push_s       = 1'b0;
    push_entry_s = EMPTY_ENTRY;
    if (redirect_in) begin
      push_s = 1'b0;
    end else if (misalign_pend_r) begin
      push_s       = 1'b1;
      push_entry_s = '{pc: pc_r, instr: NOP_INSTR, fault: 1'b0, misalign: 1'b1};
    end else if (accept_s) begin
      push_s       = 1'b1;
      push_entry_s = '{pc: pc_r, instr: (i_err_in ? NOP_INSTR : i_rdata_in),
                       fault: i_err_in, misalign: 1'b0};
    end else begin
      push_s = 1'b0;
    end
  end

  // PC, halt and misalign-pending state; redirect overrides everything.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pc_r            <= RESET_PC;
      halt_r          <= 1'b0;
      misalign_pend_r <= 1'b0;
    end else if (redirect_in) begin
      pc_r            <= target_pc_in;
      halt_r          <= pc_misaligned(target_pc_in);
      misalign_pend_r <= pc_misaligned(target_pc_in);
    end else begin
      misalign_pend_r <= 1'b0;
      if (accept_s) begin
        pc_r   <= pc_r + 32'd4;
        halt_r <= halt_r | i_err_in;
      end
    end
  end

  msrv32_fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .push       (push_s),
    .pop        (pop_s),
    .flush      (redirect_in),
    .push_entry (push_entry_s),
    .full       (q_full_s),
    .empty      (q_empty_s),
    .head       (head_s)
  );

  // Decode-facing fields come straight from the head register.
  assign instr_out          = head_s.instr;
  assign pc_out             = head_s.pc;
  assign imm_instr_out      = head_s.instr[IMM_MSB:IMM_LSB];
  assign opcode_out         = head_s.instr[OPC_MSB:OPC_LSB];
  assign funct3_out         = head_s.instr[F3_MSB:F3_LSB];
  assign rd_addr_out        = head_s.instr[RD_MSB:RD_LSB];
  assign rs1_addr_out       = head_s.instr[RS1_MSB:RS1_LSB];
  assign rs2_addr_out       = head_s.instr[RS2_MSB:RS2_LSB];
  assign fetch_fault_out    = instr_valid_out & head_s.fault;
  assign fetch_misalign_out = instr_valid_out & head_s.misalign;

endmodule
